// File: rtl/adder_pkg.sv
// Shared types and constants for the adder_top command driver.
package adder_pkg;

  localparam int unsigned RSP_CNT_W = 16;
  // Operand fields are sized for the widest supported N; users must keep N <= CMD_MAX_W.
  localparam int unsigned CMD_MAX_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SET,
    GET,
    WAIT,
    RSP
  } state_t;

  typedef struct packed {
    logic [CMD_MAX_W-1:0] a;
    logic [CMD_MAX_W-1:0] b;
    logic                 use_b;
  } cmd_t;

endpackage

// File: rtl/adder_cmd_fifo.sv
// Command FIFO for adder_driver: {a, b, use_b} entries packed as a 2N+1-bit word.
module adder_cmd_fifo #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [2*N:0]             i_wdata,
  output logic [2*N:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [2*N:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_wdata;
  end

endmodule

// File: rtl/adder_driver.sv
// Queues add commands and sequences adder_top set/get strobes, returning each sum in order.
// Optional response counter: define ADDER_DRIVER_STATS_EN.
module adder_driver
  import adder_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned RES_LAT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [N-1:0]         cmd_a,
  input  logic [N-1:0]         cmd_b,
  input  logic                 cmd_use_b,
  output logic                 set1,
  output logic                 set2,
  output logic                 get,
  output logic [N-1:0]         data1,
  output logic [N-1:0]         data2,
  input  logic [N-1:0]         result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_data
`ifdef ADDER_DRIVER_STATS_EN
  ,
  output logic [RSP_CNT_W-1:0] rsp_count
`endif
);

  state_t r_state;
  logic   r_ready_en;
  logic   r_set1, r_set2, r_get, r_rsp_valid;
  logic [N-1:0] r_data1, r_data2, r_rsp_data;
  logic [2:0]   r_lat;

  logic         w_push, w_pop, w_full, w_empty;
  logic [2*N:0] w_rdata;
  logic [$clog2(DEPTH):0] w_count;
  cmd_t         w_head;
  logic [$bits(cmd_t)+$clog2(DEPTH):0] w_unused_sink;

  assign cmd_ready = r_ready_en & ~w_full;
  assign w_push    = cmd_valid & cmd_ready;
  assign w_pop     = (r_state == RSP) & rsp_ready;

  adder_cmd_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({cmd_a, cmd_b, cmd_use_b}),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head = '{a:     CMD_MAX_W'(w_rdata[2*N:N+1]),
                    b:     CMD_MAX_W'(w_rdata[N:1]),
                    use_b: w_rdata[0]};
  // Padding bits of the head struct and the occupancy count are not needed here.
  assign w_unused_sink = {w_head, w_count};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ready_en  <= 1'b0;
      r_set1      <= 1'b0;
      r_set2      <= 1'b0;
      r_get       <= 1'b0;
      r_data1     <= '0;
      r_data2     <= '0;
      r_lat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_ready_en <= 1'b1;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state <= SET;
            r_set1  <= 1'b1;
            r_data1 <= w_head.a[N-1:0];
            r_set2  <= w_head.use_b;
            r_data2 <= w_head.use_b ? w_head.b[N-1:0] : '0;
          end
        end
        SET: begin
          r_state <= GET;
          r_set1  <= 1'b0;
          r_set2  <= 1'b0;
          r_data1 <= '0;
          r_data2 <= '0;
          r_get   <= 1'b1;
        end
        GET: begin
          r_state <= WAIT;
          r_get   <= 1'b0;
          r_lat   <= 3'd1;
        end
        WAIT: begin
          if (r_lat == 3'(RES_LAT)) begin
            r_state     <= RSP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= result;
          end else begin
            r_lat <= r_lat + 3'd1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign set1      = r_set1;
  assign set2      = r_set2;
  assign get       = r_get;
  assign data1     = r_data1;
  assign data2     = r_data2;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

`ifdef ADDER_DRIVER_STATS_EN
  logic [RSP_CNT_W-1:0] r_rsp_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rsp_count <= '0;
    end else if (w_pop && (r_rsp_count != '1)) begin
      r_rsp_count <= r_rsp_count + 1'b1;
    end
  end

  assign rsp_count = r_rsp_count;
`else
  // Response counter not built.
`endif

endmodule

// File: tb/tb_adder_driver.sv
// Directed table-driven bench for adder_driver with a behavioural adder_top model.
module tb_adder_driver;

  localparam int unsigned N = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_use_b = 1'b0;
  logic         rsp_ready = 1'b1;
  logic [N-1:0] cmd_a = '0;
  logic [N-1:0] cmd_b = '0;
  logic         cmd_ready, set1, set2, get, rsp_valid;
  logic [N-1:0] data1, data2, result, rsp_data;
`ifdef ADDER_DRIVER_STATS_EN
  logic [15:0]  rsp_count;
`endif

  int checks = 0;
  int errors = 0;

  adder_driver #(
    .N       (N),
    .DEPTH   (4),
    .RES_LAT (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_use_b (cmd_use_b),
    .set1      (set1),
    .set2      (set2),
    .get       (get),
    .data1     (data1),
    .data2     (data2),
    .result    (result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
`ifdef ADDER_DRIVER_STATS_EN
    ,
    .rsp_count (rsp_count)
`endif
  );

  always #5 clock = ~clock;

  // adder_top model: latch operands on set strobes, add on get; no set2 means accumulate.
  logic [N-1:0] m_op1, m_op2, m_sum;
  logic         m_bld;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_op1 <= '0; m_op2 <= '0; m_sum <= '0; m_bld <= 1'b0;
    end else begin
      if (set1) m_op1 <= data1;
      if (set2) begin m_op2 <= data2; m_bld <= 1'b1; end
      if (get) begin
        m_sum <= m_op1 + (m_bld ? m_op2 : m_sum);
        m_bld <= 1'b0;
      end
    end
  end
  assign result = m_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       use_b;
    logic [7:0] rsp;
  } vec_t;

  // Called at a negedge with the FIFO empty and the FSM idle; ends at a negedge, idle again.
  task automatic run_single(input vec_t v, input string tag);
    cmd_valid = 1'b1; cmd_a = v.a; cmd_b = v.b; cmd_use_b = v.use_b;
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    @(negedge clock);
    cmd_valid = 1'b0;
    chk({tag, "_c1_set1"}, 32'(set1), 32'd0);
    @(negedge clock);
    chk({tag, "_c2_strobes"}, {29'd0, set1, set2, get}, {29'd0, 1'b1, v.use_b, 1'b0});
    chk({tag, "_c2_data1"}, 32'(data1), 32'(v.a));
    chk({tag, "_c2_data2"}, 32'(data2), v.use_b ? 32'(v.b) : 32'd0);
    @(negedge clock);
    chk({tag, "_c3_get"}, {29'd0, set1, set2, get}, 32'd1);
    chk({tag, "_c3_data"}, {data1, data2}, 32'd0);
    @(negedge clock);
    chk({tag, "_c4_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clock);
    chk({tag, "_c5_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_c5_data"}, 32'(rsp_data), 32'(v.rsp));
    @(negedge clock);
    chk({tag, "_c6_done"}, 32'(rsp_valid), 32'd0);
  endtask

  vec_t tbl[6];
  logic [7:0] fill_exp[5];

  initial begin
    int n;
    logic bad;

    tbl[0] = '{a: 8'h01, b: 8'hFF, use_b: 1'b1, rsp: 8'h00};
    tbl[1] = '{a: 8'h01, b: 8'h00, use_b: 1'b0, rsp: 8'h01};
    tbl[2] = '{a: 8'h10, b: 8'h20, use_b: 1'b1, rsp: 8'h30};
    tbl[3] = '{a: 8'h05, b: 8'h77, use_b: 1'b0, rsp: 8'h35};
    tbl[4] = '{a: 8'h80, b: 8'h80, use_b: 1'b1, rsp: 8'h00};
    tbl[5] = '{a: 8'hFF, b: 8'h12, use_b: 1'b0, rsp: 8'hFF};
    fill_exp = '{8'h03, 8'h07, 8'h0B, 8'h0F, 8'h13};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_ctrl", {27'd0, set1, set2, get, rsp_valid, cmd_ready}, 32'd0);
    chk("rst_data", {8'd0, data1, data2, rsp_data}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge clock);
    chk("rel_ready_after_edge", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_single(tbl[i], $sformatf("vec%0d", i));
`ifdef ADDER_DRIVER_STATS_EN
    chk("stats_after_table", 32'(rsp_count), 32'd6);
`endif

    // Fill with the consumer stalled, then backpressure on the first response
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_a = 8'(2*i+1); cmd_b = 8'(2*i+2); cmd_use_b = 1'b1;
      chk($sformatf("fill_ready%0d", i), 32'(cmd_ready), 32'd1);
      @(negedge clock);
    end
    cmd_a = 8'd9; cmd_b = 8'd10;
    chk("fill_full", 32'(cmd_ready), 32'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clock); n++; end
    chk("fill_rsp0_seen", 32'(rsp_valid), 32'd1);
    chk("fill_rsp0_data", 32'(rsp_data), 32'(fill_exp[0]));
    bad = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (!rsp_valid || rsp_data !== fill_exp[0] || set1 || cmd_ready) bad = 1'b1;
    end
    chk("bp_stable", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clock);
    chk("fill_hs_valid", 32'(rsp_valid), 32'd0);
    chk("fill_room", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("fill_fifth_taken", 32'(cmd_ready), 32'd0);
    for (int j = 1; j < 5; j++) begin
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clock); n++; end
      chk($sformatf("fill_rsp%0d_seen", j), 32'(rsp_valid), 32'd1);
      chk($sformatf("fill_rsp%0d_data", j), 32'(rsp_data), 32'(fill_exp[j]));
      @(negedge clock);
    end

    // Reset while the first of three queued commands is in WAIT
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_a = 8'(i+2); cmd_b = 8'd3; cmd_use_b = 1'b1;
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    @(negedge clock);
    chk("wait_pre_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    #1;
    chk("wait_rst_ctrl", {27'd0, set1, set2, get, rsp_valid, cmd_ready}, 32'd0);
    chk("wait_rst_data", {8'd0, data1, data2, rsp_data}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("wait_rel_ready", 32'(cmd_ready), 32'd1);
    bad = 1'b0;
    repeat (15) begin
      @(negedge clock);
      if (rsp_valid || set1 || get) bad = 1'b1;
    end
    chk("wait_no_ghost", 32'(bad), 32'd0);

    run_single(tbl[0], "post0");
    run_single(tbl[2], "post2");
    run_single(tbl[4], "post4");
`ifdef ADDER_DRIVER_STATS_EN
    chk("stats_three", 32'(rsp_count), 32'd3);
    reset = 1'b1;
    #1;
    chk("stats_reset", 32'(rsp_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
